etapa_mem_wb: RTL

MEM stage plus MEM/WB pipeline register of the MIPS pipeline. It holds the data memory, performs byte/halfword/word stores and loads with sign or zero extension, and builds the LUI value. It registers the results that feed the writeback memory-to-register mux, which selects between o_MemDatos and o_ALU. Stall and flush come from the hazard unit.

---
 rtl/mips_pkg.sv | 9 +
 rtl/filtro_carga.sv | 28 ++
 rtl/etapa_mem_wb.sv | 107 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and width defaults for the MIPS pipeline stages.
package mips_pkg;
   localparam int NBITS_DEF     = 32;
   localparam int NBITS_REG_DEF = 5;

   localparam logic [1:0] TAM_BYTE = 2'b00;
   localparam logic [1:0] TAM_HALF = 2'b01;
   localparam logic [1:0] TAM_WORD = 2'b11;
endpackage

// File: rtl/filtro_carga.sv
// Load filter: picks the addressed byte/half of a memory word and sign- or zero-extends it.
// Purely combinational, no flow control.
module filtro_carga
   import mips_pkg::*;
#(
   parameter int NBITS = NBITS_DEF
) (
   input  logic [NBITS-1:0] palabra,
   input  logic [1:0]       addr,
   input  logic [1:0]       tamano,
   input  logic             zero_ext,
   output logic [NBITS-1:0] dato
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = palabra[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? palabra[16 +: 16] : palabra[0 +: 16];
      case (tamano)
         TAM_BYTE: dato = {{(NBITS-8){~zero_ext & byte_sel[7]}}, byte_sel};
         TAM_HALF: dato = {{(NBITS-16){~zero_ext & half_sel[15]}}, half_sel};
         default:  dato = palabra;
      endcase
   end

endmodule

// File: rtl/etapa_mem_wb.sv
// MEM stage (data memory, sized stores, filtered loads, LUI) plus the MEM/WB register.
// One cycle latency; stall holds the register, flush inserts a bubble, both suppress stores.
module etapa_mem_wb
   import mips_pkg::*;
#(
   parameter int NBITS      = NBITS_DEF,
   parameter int NBITS_REG  = NBITS_REG_DEF,
   parameter int DEPTH_BITS = 10
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_Stall,
   input  logic                 i_Flush,
   input  logic                 i_MemRead,
   input  logic                 i_MemWrite,
   input  logic                 i_MemToReg,
   input  logic                 i_RegWrite,
   input  logic                 i_LUI,
   input  logic [1:0]           i_Tamano,
   input  logic                 i_ZeroExt,
   input  logic [NBITS-1:0]     i_ALU,
   input  logic [NBITS-1:0]     i_DatoEscritura,
   input  logic [15:0]          i_Inmediato,
   input  logic [NBITS_REG-1:0] i_RegDestino,
   output logic [NBITS-1:0]     o_MemDatos,
   output logic [NBITS-1:0]     o_ALU,
   output logic                 o_MemToReg,
   output logic                 o_RegWrite,
   output logic [NBITS_REG-1:0] o_RegDestino,
   output logic                 o_Desalineado
);

   localparam int NLANES = NBITS / 8;

   logic [NBITS-1:0]      mem [2**DEPTH_BITS];
   logic [DEPTH_BITS-1:0] idx;
   logic [1:0]            off;
   logic [NBITS-1:0]      rd_word, load_dat, st_dat, wr_word, dat_next;
   logic [NLANES-1:0]     be;
   logic                  desal, we;

   assign idx     = i_ALU[DEPTH_BITS+1:2];
   assign off     = i_ALU[1:0];
   assign rd_word = mem[idx];

   filtro_carga #(.NBITS(NBITS)) u_filtro (
      .palabra  (rd_word),
      .addr     (off),
      .tamano   (i_Tamano),
      .zero_ext (i_ZeroExt),
      .dato     (load_dat)
   );

   // Store data is replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      desal  = 1'b0;
      be     = '1;
      st_dat = i_DatoEscritura;
      case (i_Tamano)
         TAM_BYTE: begin
            be     = NLANES'(1) << off;
            st_dat = {NLANES{i_DatoEscritura[7:0]}};
         end
         TAM_HALF: begin
            desal  = off[0];
            be     = NLANES'(2'b11) << {off[1], 1'b0};
            st_dat = {(NLANES/2){i_DatoEscritura[15:0]}};
         end
         default: desal = |off;
      endcase
      desal = desal & (i_MemRead | i_MemWrite);

      wr_word = rd_word;
      for (int k = 0; k < NLANES; k++)
         if (be[k]) wr_word[8*k +: 8] = st_dat[8*k +: 8];

      if (i_LUI)          dat_next = {i_Inmediato, {(NBITS-16){1'b0}}};
      else if (desal)     dat_next = '0;
      else if (i_MemRead) dat_next = load_dat;
      else                dat_next = '0;
   end

   assign we = i_MemWrite & ~desal & ~i_Stall & ~i_Flush & ~i_reset;

   always_ff @(posedge i_clk) begin
      if (we) mem[idx] <= wr_word;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset || i_Flush) begin
         o_MemDatos    <= '0;
         o_ALU         <= '0;
         o_MemToReg    <= 1'b0;
         o_RegWrite    <= 1'b0;
         o_RegDestino  <= '0;
         o_Desalineado <= 1'b0;
      end else if (!i_Stall) begin
         o_MemDatos    <= dat_next;
         o_ALU         <= i_ALU;
         o_MemToReg    <= i_MemToReg;
         o_RegWrite    <= i_RegWrite & ~desal;
         o_RegDestino  <= i_RegDestino;
         o_Desalineado <= desal;
      end
   end

endmodule
